// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - 8N1 UART receiver with one-cycle valid/frame_err pulses
// Optional UART_RECV_MAJORITY_EN: 2-of-3 vote on data and stop bits.
module uart_recv #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       valid,
  output logic [7:0] recv_data,
  output logic       frame_err
);

  localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
  localparam logic [13:0] CNT_LAST  = 14'(DIVIDER - 1);
  localparam logic [13:0] HALF_LAST = 14'(DIVIDER / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERR} state_t;

  state_t      state, state_nxt;
  logic [13:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  sh, sh_nxt;
  logic [7:0]  recv_nxt;
  logic        valid_nxt, ferr_nxt;
  logic        rx_m, rx_s;
  logic        bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RECV_MAJORITY_EN
  // Two early samples are held so the vote completes on the bit-centre cycle.
  logic [1:0] votes;
  always_ff @(posedge clk) begin
    if (rst) begin
      votes <= 2'b11;
    end else if (state == DATA || state == STOP) begin
      if (cnt == CNT_LAST - 14'd2) votes[0] <= rx_s;
      if (cnt == CNT_LAST - 14'd1) votes[1] <= rx_s;
    end
  end
  assign bit_val = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      recv_data <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      sh        <= sh_nxt;
      recv_data <= recv_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    recv_nxt  = recv_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 14'd1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          // Wire order is LSB first, so each new bit enters at the top.
          sh_nxt  = {bit_val, sh[7:1]};
          cnt_nxt = '0;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 14'd1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (bit_val) begin
            recv_nxt  = sh;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ERR;
          end
        end else begin
          cnt_nxt = cnt + 14'd1;
        end
      end
      ERR: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - self-checking bench for uart_recv against a frame-level model
module tb_uart_recv;

  localparam int CLK_FREQ  = 320_000;
  localparam int BAUD_RATE = 10_000;
  localparam int D         = CLK_FREQ / BAUD_RATE;
  localparam int LAT       = 2 + 1 + D / 2 + 9 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       valid;
  logic [7:0] recv_data;
  logic       frame_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_cnt = 0;
  int         overlap  = 0;
  int         wide     = 0;
  logic       prev_v   = 1'b0;
  logic       prev_e   = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_recv #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .valid(valid), .recv_data(recv_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(recv_data);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) overlap++;
    if ((valid && prev_v) || (frame_err && prev_e)) wide++;
    prev_v = valid;
    prev_e = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
    ferr_cnt = 0;
  endtask

  // glitch_bit >= 0 pulls the line low for one cycle at that data bit's centre.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit,
                            output int t0);
    uart_rx = 1'b0;
    t0 = cyc;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      if (i == glitch_bit) begin
        tick(D / 2);
        uart_rx = 1'b0;
        tick(1);
        uart_rx = data[i];
        tick(D - D / 2 - 1);
      end else begin
        tick(D);
      end
    end
    uart_rx = stop;
    tick(D);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] exp[$]);
    checks++;
    if (got_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL %s count: got %0d expected %0d", name, got_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin
        fails++;
        $display("FAIL %s byte%0d: got none expected %02h", name, i, exp[i]);
      end else if (got_q[i] !== exp[i]) begin
        fails++;
        $display("FAIL %s byte%0d: got %02h expected %02h", name, i, got_q[i], exp[i]);
      end
    end
    if (exp.size() > 0) last_good = exp[exp.size() - 1];
  endtask

  task automatic test_reset();
    tick(3);
    checks += 3;
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    if (recv_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %02h expected 00", recv_data); end
    rst = 1'b0;
    tick(2 * D);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      fails++;
      $display("FAIL idle_quiet: got %0d valid %0d ferr expected 0 0", got_q.size(), ferr_cnt);
    end
  endtask

  task automatic test_single();
    int t0;
    logic [7:0] exp[$];
    clear_obs();
    send_frame(8'h73, 1'b1, -1, t0);
    wait_rx(1, 4 * D);
    exp = '{8'h73};
    expect_bytes("single", exp);
    if (got_t.size() > 0) begin
      checks++;
      if (got_t[0] - t0 < LAT - 2 || got_t[0] - t0 > LAT + 2) begin
        fails++;
        $display("FAIL latency: got %0d expected %0d", got_t[0] - t0, LAT);
      end
    end
    tick(D);
    checks += 2;
    if (recv_data !== 8'h73) begin fails++; $display("FAIL hold_data: got %02h expected 73", recv_data); end
    if (ferr_cnt != 0) begin fails++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] exp[$];
    clear_obs();
    exp = '{8'h73, 8'h74, 8'h61, 8'h72, 8'h74, 8'h0D};
    foreach (exp[i]) send_frame(exp[i], 1'b1, -1, t0);
    wait_rx(6, 4 * D);
    expect_bytes("b2b", exp);
    for (int i = 1; i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] - got_t[i - 1] != 10 * D) begin
        fails++;
        $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, got_t[i] - got_t[i - 1], 10 * D);
      end
    end
  endtask

  task automatic test_glitch();
    int t0;
    logic [7:0] exp[$];
    clear_obs();
    for (int g = 0; g < 3; g++) begin
      uart_rx = 1'b0;
      tick($urandom_range(D / 2 - 1, 1));
      uart_rx = 1'b1;
      tick(2 * D);
    end
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      fails++;
      $display("FAIL glitch_quiet: got %0d valid %0d ferr expected 0 0", got_q.size(), ferr_cnt);
    end
    send_frame(8'h68, 1'b1, -1, t0);
    wait_rx(1, 4 * D);
    exp = '{8'h68};
    expect_bytes("after_glitch", exp);
  endtask

  task automatic test_frame_error();
    int t0;
    logic [7:0] exp[$];
    logic [7:0] held;
    clear_obs();
    held = last_good;
    send_frame(8'h55, 1'b0, -1, t0);
    tick(2 * D);
    uart_rx = 1'b1;
    tick(D);
    checks += 3;
    if (ferr_cnt != 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); end
    if (got_q.size() != 0) begin fails++; $display("FAIL ferr_valid: got %0d expected 0", got_q.size()); end
    if (recv_data !== held) begin fails++; $display("FAIL ferr_data: got %02h expected %02h", recv_data, held); end
    clear_obs();
    send_frame(8'h0D, 1'b1, -1, t0);
    wait_rx(1, 4 * D);
    exp = '{8'h0D};
    expect_bytes("after_ferr", exp);
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] b;
    logic [7:0] exp[$];
    clear_obs();
    b = 8'h7A;
    uart_rx = 1'b0;
    tick(D);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      tick(D);
    end
    uart_rx = b[4];
    tick(D / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks += 3;
    if (valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", valid); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL mid_rst_ferr: got %b expected 0", frame_err); end
    if (recv_data !== 8'h00) begin fails++; $display("FAIL mid_rst_data: got %02h expected 00", recv_data); end
    uart_rx = 1'b1;
    tick(12 * D);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      fails++;
      $display("FAIL mid_rst_quiet: got %0d valid %0d ferr expected 0 0", got_q.size(), ferr_cnt);
    end
    send_frame(8'h7A, 1'b1, -1, t0);
    wait_rx(1, 4 * D);
    exp = '{8'h7A};
    expect_bytes("after_mid_rst", exp);
  endtask

  task automatic test_majority();
    int t0;
    logic [7:0] exp[$];
    clear_obs();
    send_frame(8'hFF, 1'b1, 3, t0);
    wait_rx(1, 4 * D);
`ifdef UART_RECV_MAJORITY_EN
    exp = '{8'hFF};
`else
    exp = '{8'hF7};
`endif
    expect_bytes("majority", exp);
  endtask

  task automatic test_random_stream();
    int t0;
    logic [7:0] exp[$];
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b, 1'b1, -1, t0);
      tick($urandom_range(D, 0));
    end
    wait_rx(12, 4 * D);
    expect_bytes("random", exp);
  endtask

  task automatic test_pulse_rules();
    checks += 2;
    if (overlap != 0) begin fails++; $display("FAIL pulse_overlap: got %0d expected 0", overlap); end
    if (wide != 0) begin fails++; $display("FAIL pulse_width: got %0d expected 0", wide); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_majority();
    test_random_stream();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver for the string-matching datapath: deserialises the 8N1 serial input at `BAUD_RATE` and presents each received byte as a one-cycle `valid` pulse with `recv_data`. It sits directly upstream of `string_match`, driving that block's `valid`/`recv_data` inputs. The two blocks share the board clock, so no handshake or back-pressure is needed.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: serial bit rate.
- `DIVIDER`, CLK_FREQ/BAUD_RATE (10416): clocks per bit. Localparam, integer division.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `uart_rx` in 1: asynchronous serial line. Idles high.
- `valid` out 1: one-cycle pulse when a good frame completes.
- `recv_data` out 8: last good byte. Updated in the same cycle `valid` rises, then held.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.

## Operation
- **Input synchroniser:** 2-FF synchroniser on `uart_rx` produces `rx_s`. Both FFs reset to 1.
- **State machine** with states IDLE, START, DATA, STOP, ERR. Uses a bit counter `cnt` (14 bits, range 0..DIVIDER-1), a bit index `idx` (3 bits) and an 8-bit shift register `sh`.
- **IDLE:** `cnt`=0. When `rx_s`==0, go to START.
- **START:** `cnt` increments.
  - At `cnt`==DIVIDER/2-1 (5207) with `rx_s`==0: set `cnt`=0, `idx`=0, go to DATA.
  - At the same point with `rx_s`==1: glitch. Go to IDLE and produce no output.
- **DATA:** `cnt` increments.
  - At `cnt`==DIVIDER-1 (the bit centre), the sampled bit shifts into `sh` MSB-first-in / LSB-first-on-wire: `sh <= {bit, sh[7:1]}`.
  - Then `cnt`=0. When `idx`==7 go to STOP, otherwise `idx`++.
- **STOP:** at `cnt`==DIVIDER-1, sample the stop bit.
  - Sample 1: `recv_data<=sh`, `valid<=1`, go to IDLE. The return happens at mid-stop-bit, so a back-to-back start bit is caught.
  - Sample 0: `frame_err<=1`, `recv_data` unchanged, go to ERR.
- **ERR:** wait for `rx_s`==1, then go to IDLE. This prevents a held-low line being taken as a new start bit.
- **Pulse width:** `valid` and `frame_err` are high for exactly one cycle and are never high together.
- **Reset** (any state, including mid-frame): the next cycle is IDLE, with `cnt`=0, `idx`=0, `sh`=0, `valid`=0, `frame_err`=0, `recv_data`=8'h00, and the synchroniser FFs at 1. A partial frame is discarded.

## Timing
- **Reset values:** `valid`=0, `frame_err`=0, `recv_data`=8'h00.
- **Latency:** `valid` rises 2 (sync) + 1 + DIVIDER/2 + 9*DIVIDER cycles after the `uart_rx` falling edge of the start bit.
  - That is 98955 cycles at default parameters; tolerance ±2 cycles.
- **Back-to-back frames:** the minimum frame spacing accepted is 10*DIVIDER cycles (stop bit immediately followed by the next start bit). Successive `valid` pulses are then 10*DIVIDER apart.
- **Glitch rejection:** any low pulse shorter than DIVIDER/2 cycles that returns high before the START check produces no output.
- **Clock tolerance:** sampling is at bit centre, so the block tolerates about ±4% rate mismatch over a frame.

## Configuration
- **`UART_RECV_MAJORITY_EN` defined:** each data and stop bit is a 2-of-3 majority vote of `rx_s` sampled at `cnt`==DIVIDER-3, DIVIDER-2 and DIVIDER-1.
  - The vote is applied at DIVIDER-1; the capture/transition timing is unchanged.
  - The START check stays single-sample.
- **Undefined:** single sample at `cnt`==DIVIDER-1. No vote registers are present.
- Port list and latency are identical in both builds.

## Test plan
- **Single byte:** drive 0x73 8N1 at 9600 baud after reset.
  - Expect exactly one `valid` pulse about 98955 cycles after the start edge, with `recv_data`=0x73 and `frame_err` staying 0.
- **Back-to-back stream:** send "start\r" (0x73 0x74 0x61 0x72 0x74 0x0D) with no idle gap.
  - Expect six `valid` pulses 104160 cycles apart carrying those bytes in order.
- **Glitch:** pull `uart_rx` low for 1000 cycles, then high.
  - Expect no `valid`, no `frame_err`, state back in IDLE. A following 0x68 is received correctly.
- **Framing error:** send 0x55 with a low stop bit and hold the line low for 2 bit times, then release.
  - Expect one `frame_err` pulse, no `valid`, `recv_data` unchanged.
  - A following 0x0D is received with `valid`.
- **Reset mid-frame:** assert `rst` for one cycle during data bit 4 of 0x7A.
  - Expect outputs at 0 and no `valid` for that frame. The next 0x7A is received correctly.
- **Majority vote:** send 0xFF with a 1-cycle low glitch on the synchronised line at data bit 3's `cnt`==DIVIDER-1.
  - With `UART_RECV_MAJORITY_EN` defined: `recv_data`=0xFF.
  - Without it: `recv_data`=0xF7.
